// File: rtl/sba_bus_arbiter.sv
// Two-requester arbiter sharing one request/grant/response bus between the core
// data port (m0) and the debug system-bus master (m1); responses return in order.
module sba_bus_arbiter #(
  parameter int unsigned BusWidth       = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned DbgPriority    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  m0_req_i,
  input  logic [BusWidth-1:0]   m0_add_i,
  input  logic                  m0_we_i,
  input  logic [BusWidth-1:0]   m0_wdata_i,
  input  logic [BusWidth/8-1:0] m0_be_i,
  output logic                  m0_gnt_o,
  output logic                  m0_r_valid_o,
  output logic                  m0_r_err_o,
  output logic [BusWidth-1:0]   m0_r_rdata_o,

  input  logic                  m1_req_i,
  input  logic [BusWidth-1:0]   m1_add_i,
  input  logic                  m1_we_i,
  input  logic [BusWidth-1:0]   m1_wdata_i,
  input  logic [BusWidth/8-1:0] m1_be_i,
  output logic                  m1_gnt_o,
  output logic                  m1_r_valid_o,
  output logic                  m1_r_err_o,
  output logic [BusWidth-1:0]   m1_r_rdata_o,

  output logic                  bus_req_o,
  output logic [BusWidth-1:0]   bus_add_o,
  output logic                  bus_we_o,
  output logic [BusWidth-1:0]   bus_wdata_o,
  output logic [BusWidth/8-1:0] bus_be_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_r_valid_i,
  input  logic                  bus_r_err_i,
  input  logic [BusWidth-1:0]   bus_r_rdata_i,

  output logic                  busy_o,
  output logic                  spurious_rsp_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state_q;
  logic                owner_q;
  logic                last_gnt_q;
  logic [CntW-1:0]     cnt_q;
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic                spurious_q;
  logic [MaxOutstanding-1:0] ids_q;

  logic arb_owner;
  logic owner;
  logic owner_req;
  logic full;
  logic empty;
  logic hs;
  logic pop;
  logic head;

  always_comb begin
    arb_owner = 1'b0;
    if (m0_req_i && m1_req_i) begin
      arb_owner = (DbgPriority != 0) ? 1'b1 : ~last_gnt_q;
    end else if (m1_req_i) begin
      arb_owner = 1'b1;
    end
  end

  // While locked the owner is frozen so the address stays stable until grant.
  assign owner     = (state_q == LOCKED) ? owner_q : arb_owner;
  assign owner_req = owner ? m1_req_i : m0_req_i;
  assign full      = (cnt_q == CntW'(MaxOutstanding));
  assign empty     = (cnt_q == '0);

  assign bus_req_o   = owner_req & ~full & ~rst_i;
  assign bus_add_o   = owner ? m1_add_i   : m0_add_i;
  assign bus_we_o    = owner ? m1_we_i    : m0_we_i;
  assign bus_wdata_o = owner ? m1_wdata_i : m0_wdata_i;
  assign bus_be_o    = owner ? m1_be_i    : m0_be_i;

  assign hs       = bus_req_o & bus_gnt_i;
  assign m0_gnt_o = hs & ~owner;
  assign m1_gnt_o = hs & owner;

  // Responses come back in grant order; the FIFO head names the requester.
  assign head         = ids_q[rd_ptr_q];
  assign pop          = bus_r_valid_i & ~empty & ~rst_i;
  assign m0_r_valid_o = pop & ~head;
  assign m1_r_valid_o = pop & head;
  assign m0_r_err_o   = pop & ~head & bus_r_err_i;
  assign m1_r_err_o   = pop & head & bus_r_err_i;
  assign m0_r_rdata_o = bus_r_rdata_i;
  assign m1_r_rdata_o = bus_r_rdata_i;

  assign busy_o         = ~empty;
  assign spurious_rsp_o = spurious_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      spurious_q <= 1'b0;
    end else begin
      case (state_q)
        ARB: begin
          if (bus_req_o && !bus_gnt_i) begin
            state_q <= LOCKED;
            owner_q <= arb_owner;
          end
        end
        LOCKED: begin
          // A dropped request while locked is abandoned rather than held.
          if (bus_gnt_i || !bus_req_o) state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase

      if (hs) begin
        last_gnt_q <= owner;
        wr_ptr_q   <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (hs && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !hs) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (bus_r_valid_i && empty) spurious_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (hs) ids_q[wr_ptr_q] <= owner;
  end

endmodule
